// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - 32-bit MEM-stage access sequencer for a 16-bit asynchronous SRAM
//
// Ports:
//   clk, rst           clock; synchronous active-low reset
//   rd_en, wr_en       access requests from the EX-stage register (write wins if both)
//   address            CPU byte address; BASE_ADDR maps to SRAM word 0
//   write_data         32-bit store data
//   read_data          last completed read word, valid from DONE onwards
//   ready              high when no access is pending; pipeline freeze = ~ready
//   sram_addr          SRAM halfword address
//   sram_dq_out        write data to the pad
//   sram_dq_oe         pad output enable
//   sram_dq_in         read data from the pad
//   sram_we_n          SRAM write strobe, active-low

module sram_controller #(
    parameter int BASE_ADDR   = 1024,
    parameter int SRAM_ADDR_W = 18,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [15:0]            sram_dq_out,
    output logic                   sram_dq_oe,
    input  logic [15:0]            sram_dq_in,
    output logic                   sram_we_n
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int                CNT_W    = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WAIT_CYCLES);
    localparam logic [31:0]       BASE     = 32'(BASE_ADDR);

    state_t                 state;
    state_t                 state_next;
    logic [CNT_W-1:0]       cnt;
    logic                   op_write;
    logic [SRAM_ADDR_W-2:0] word;
    logic [31:0]            wdata;
    logic [15:0]            stage_lo;

    logic                   req;
    logic                   phase_end;
    logic [SRAM_ADDR_W-2:0] word_in;

    assign req       = rd_en | wr_en;
    assign phase_end = (cnt == CNT_LAST);

    // Modulo-2^32 offset from the window base; the byte lane bits and anything
    // above the SRAM word range fall away in the cast.
    assign word_in = (SRAM_ADDR_W-1)'((address - BASE) >> 2);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req) state_next = LOW;
            LOW:     if (phase_end) state_next = HIGH;
            HIGH:    if (phase_end) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Pad outputs come only from registered state so the SRAM never sees a
    // glitch from the request inputs.
    always_comb begin
        ready       = ((state == IDLE) && !req) || (state == DONE);
        sram_addr   = '0;
        sram_dq_out = 16'h0000;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        if ((state == LOW) || (state == HIGH)) begin
            sram_addr = {word, (state == HIGH)};
            if (op_write) begin
                sram_dq_oe  = 1'b1;
                sram_dq_out = (state == HIGH) ? wdata[31:16] : wdata[15:0];
                // Strobe rises at the start of the last phase cycle so address
                // and data stay stable across the rising edge.
                sram_we_n   = phase_end;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= CNT_ONE;
            op_write  <= 1'b0;
            word      <= '0;
            wdata     <= 32'h0;
            stage_lo  <= 16'h0;
            read_data <= 32'h0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    cnt <= CNT_ONE;
                    if (req) begin
                        word     <= word_in;
                        wdata    <= write_data;
                        op_write <= wr_en;
                    end
                end
                LOW, HIGH: begin
                    cnt <= phase_end ? CNT_ONE : cnt + CNT_ONE;
                    if (phase_end && !op_write) begin
                        if (state == LOW) begin
                            stage_lo <= sram_dq_in;
                        end else begin
                            // High half goes straight in alongside the staged
                            // low half, so the word is valid on entry to DONE.
                            read_data <= {sram_dq_in, stage_lo};
                        end
                    end
                end
                default: cnt <= CNT_ONE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - randomized self-checking bench for sram_controller

module tb_sram_controller;

    localparam int W     = 2;
    localparam int AW    = 18;
    localparam int BASE  = 1024;
    localparam int HWS   = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rd_en = 1'b0;
    logic          wr_en = 1'b0;
    logic [31:0]   address = 32'h0;
    logic [31:0]   write_data = 32'h0;
    logic [31:0]   read_data;
    logic          ready;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_dq_out;
    logic          sram_dq_oe;
    logic [15:0]   sram_dq_in;
    logic          sram_we_n;

    int checks = 0;
    int errors = 0;

    sram_controller #(.BASE_ADDR(BASE), .SRAM_ADDR_W(AW), .WAIT_CYCLES(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .sram_addr  (sram_addr),
        .sram_dq_out(sram_dq_out),
        .sram_dq_oe (sram_dq_oe),
        .sram_dq_in (sram_dq_in),
        .sram_we_n  (sram_we_n)
    );

    always #5 clk = ~clk;

    // Asynchronous SRAM pad model, zero access time.
    logic [15:0] sram_mem [0:HWS-1];
    assign sram_dq_in = sram_mem[sram_addr];
    always @(negedge clk) begin
        if (sram_we_n === 1'b0 && sram_dq_oe === 1'b1) sram_mem[sram_addr] <= sram_dq_out;
    end

    // Reference: halfword contents expected in the SRAM, and the last read word.
    logic [15:0] ref_hw [int];
    logic [31:0] model_rd;
    logic [31:0] used_addr [$];

    function automatic logic [15:0] ref_get(input int idx);
        return ref_hw.exists(idx) ? ref_hw[idx] : 16'h0000;
    endfunction

    function automatic int word_of(input logic [31:0] a);
        logic [31:0] off;
        off = (a - 32'(BASE)) >> 2;
        return int'(off % 32'(1 << (AW - 1)));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one request (entered just after a rising edge in IDLE) and checks
    // every cycle 0..2W+1 of the access against the timing rules. Leaves the
    // request asserted; returns just after the edge that ends DONE.
    task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [31:0] d);
        int          w;
        int          cyc;
        logic        is_wr;
        logic [31:0] exp_rd;
        w      = word_of(a);
        is_wr  = wr;
        exp_rd = is_wr ? model_rd : {ref_get(2*w+1), ref_get(2*w)};
        rd_en = rd; wr_en = wr; address = a; write_data = d;
        for (int k = 0; k <= 2*W+1; k++) begin
            @(negedge clk);
            if (k == 0) begin
                check("c0_ready", 32'(ready), 32'd0);
                check("c0_we_n", 32'(sram_we_n), 32'd1);
                check("c0_oe", 32'(sram_dq_oe), 32'd0);
            end else if (k <= 2*W) begin
                cyc = (k <= W) ? k : k - W;
                check("busy_ready", 32'(ready), 32'd0);
                check("addr", 32'(sram_addr), 32'(2*w + ((k > W) ? 1 : 0)));
                check("oe", 32'(sram_dq_oe), 32'(is_wr));
                check("we_n", 32'(sram_we_n), (is_wr && cyc < W) ? 32'd0 : 32'd1);
                if (is_wr) check("dq_out", 32'(sram_dq_out), (k <= W) ? 32'(d[15:0]) : 32'(d[31:16]));
                check("rd_hold", read_data, model_rd);
            end else begin
                check("done_ready", 32'(ready), 32'd1);
                check("done_we_n", 32'(sram_we_n), 32'd1);
                check("done_oe", 32'(sram_dq_oe), 32'd0);
                check("done_rdata", read_data, exp_rd);
            end
            @(posedge clk); #1;
        end
        if (is_wr) begin
            ref_hw[2*w]   = d[15:0];
            ref_hw[2*w+1] = d[31:16];
            used_addr.push_back(a);
        end
        model_rd = exp_rd;
    endtask

    task automatic go_idle(input int gap);
        rd_en = 1'b0; wr_en = 1'b0;
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            check("idle_ready", 32'(ready), 32'd1);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        int          op;
        int          w;
        for (int i = 0; i < HWS; i++) sram_mem[i] = 16'h0000;
        model_rd = 32'h0;

        // Reset held two cycles with a read request pending.
        rst = 1'b0; rd_en = 1'b1;
        repeat (2) @(posedge clk);
        #1; rst = 1'b1; rd_en = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_we_n", 32'(sram_we_n), 32'd1);
        check("rst_oe", 32'(sram_dq_oe), 32'd0);
        check("rst_rdata", read_data, 32'h0);
        check("rst_addr", 32'(sram_addr), 32'h0);
        check("rst_dq_out", 32'(sram_dq_out), 32'h0);
        @(posedge clk); #1;

        // Directed write then read-back at 1032 (SRAM word 2, halfwords 4/5).
        run_access(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF);
        go_idle(1);
        check("wr_mem_lo", 32'(sram_mem[4]), 32'h0000BEEF);
        check("wr_mem_hi", 32'(sram_mem[5]), 32'h0000DEAD);
        run_access(1'b1, 1'b0, 32'd1032, 32'h0);
        go_idle(1);
        check("readback", read_data, 32'hDEADBEEF);

        // Held read request: one access per DONE, the next starting right after.
        run_access(1'b1, 1'b0, 32'd1032, 32'h0);
        run_access(1'b1, 1'b0, 32'd1032, 32'h0);
        go_idle(1);

        // Reset during HIGH of a write aborts it and releases the strobe.
        rd_en = 1'b0; wr_en = 1'b1; address = 32'd1024 + 32'h400; write_data = 32'hA5A55A5A;
        repeat (W + 1) begin @(posedge clk); #1; end
        @(negedge clk);
        check("abort_pre_we_n", 32'(sram_we_n), 32'd0);
        rst = 1'b0; wr_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("abort_we_n", 32'(sram_we_n), 32'd1);
        check("abort_oe", 32'(sram_dq_oe), 32'd0);
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_rdata", read_data, 32'h0);
        // Both halves saw a low strobe before the abort, so both were committed.
        w = word_of(32'd1024 + 32'h400);
        ref_hw[2*w] = 16'h5A5A; ref_hw[2*w+1] = 16'hA5A5;
        model_rd = 32'h0;
        @(posedge clk); #1;

        // Prime read_data, then simultaneous request must act as a write.
        run_access(1'b1, 1'b0, 32'd1032, 32'h0);
        go_idle(1);
        run_access(1'b1, 1'b1, 32'd1024, 32'h12345678);
        go_idle(1);
        check("both_mem0", 32'(sram_mem[0]), 32'h00005678);
        check("both_mem1", 32'(sram_mem[1]), 32'h00001234);
        check("both_rdata", read_data, 32'hDEADBEEF);
        run_access(1'b1, 1'b0, 32'd1024 + 32'h400, 32'h0);
        go_idle(1);

        // Randomized traffic: reuse of written addresses, wraparound below the
        // base, truncation above the SRAM range, random byte-lane bits.
        for (int n = 0; n < 60; n++) begin
            op = int'($urandom_range(0, 2));
            d  = $urandom;
            if (used_addr.size() > 0 && $urandom_range(0, 1) == 1)
                a = used_addr[$urandom_range(0, used_addr.size() - 1)] ^ 32'($urandom_range(0, 3));
            else if ($urandom_range(0, 1) == 1)
                a = 32'(BASE) + (32'($urandom_range(0, 63)) << 2) + 32'($urandom_range(0, 3));
            else
                a = $urandom;
            run_access(op != 1, op != 0, a, d);
            go_idle(int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sram_controller.md
# sram_controller

Sequences 32-bit data-memory accesses from the MEM stage onto a 16-bit external asynchronous SRAM. Each access takes two timed 16-bit phases. While an access is in flight the block holds `ready` low, and the pipeline uses `~ready` as the `freeze` input of every stage register. It sits between the EX-stage register outputs (ALU result as address, Rm as store data, mem_read/mem_write) and the SRAM pins.

## Interface
Parameters:
- `BASE_ADDR`, default 1024: CPU byte address mapped to SRAM word 0.
- `SRAM_ADDR_W`, default 18: SRAM address width, in 16-bit halfword units.
- `WAIT_CYCLES`, default 2: cycles per 16-bit phase; legal minimum is 2.

Ports:
- `clk`  in  1: clock; all state changes on the rising edge.
- `rst`  in  1: synchronous, active-low reset.
- `rd_en`  in  1: read request (mem_read from the EX-stage register).
- `wr_en`  in  1: write request (mem_write).
- `address`  in  32: byte address (ALU result).
- `write_data`  in  32: store data (Rm).
- `read_data`  out  32: last completed read word.
- `ready`  out  1: high when no access is pending; freeze = `~ready`.
- `sram_addr`  out  SRAM_ADDR_W: SRAM halfword address.
- `sram_dq_out`  out  16: write data to the pad.
- `sram_dq_oe`  out  1: pad output enable.
- `sram_dq_in`  in  16: read data from the pad.
- `sram_we_n`  out  1: SRAM write strobe, active-low.

## Operation
- States: IDLE, LOW, HIGH, DONE. Cycle counter `cnt` runs 1..WAIT_CYCLES within LOW and HIGH.
- **IDLE**
  - If `rd_en | wr_en`: latch address, write_data and op; go to LOW with `cnt` = 1.
  - If both are asserted, the op is a write.
- **Address arithmetic**
  - `word = (address - BASE_ADDR) >> 2`, using modulo-2^32 subtraction.
  - Bits [1:0] are ignored.
  - `word` is truncated to SRAM_ADDR_W-1 bits.
  - LOW phase: `sram_addr = {word, 1'b0}`. HIGH phase: `sram_addr = {word, 1'b1}`.
- **LOW / HIGH, write**
  - `sram_dq_oe` = 1 for the whole phase.
  - `sram_dq_out` = write_data[15:0] in LOW, [31:16] in HIGH.
  - `sram_we_n` = 0 for `cnt` < WAIT_CYCLES and 1 when `cnt` = WAIT_CYCLES, so address and data are stable across the strobe's rising edge.
- **LOW / HIGH, read**
  - `sram_dq_oe` = 0 and `sram_we_n` = 1.
  - On the edge ending `cnt` = WAIT_CYCLES, capture `sram_dq_in` into a staging register: low half in LOW, high half in HIGH.
- **Phase transitions**
  - At `cnt` = WAIT_CYCLES: LOW→HIGH, HIGH→DONE, and `cnt` resets to 1.
- **DONE**
  - Lasts one cycle with `ready` = 1.
  - For reads, `read_data` is updated from the staging register on entry to DONE, so it is valid during DONE and holds until the next read completes.
  - Requests seen in DONE are ignored; they belong to the instruction now leaving MEM. Next state is IDLE.
- **Output logic**
  - `ready = (state==IDLE & ~rd_en & ~wr_en) | state==DONE`. This is the only combinational path from request inputs.
  - All `sram_*` outputs depend only on state, `cnt` and latched registers.
- **Reset** (`rst` = 0 at a rising edge)
  - state = IDLE, `cnt` = 1, `read_data` = 0, staging register = 0, `sram_addr` = 0.
  - `sram_dq_out` = 0, `sram_dq_oe` = 0, `sram_we_n` = 1, `ready` = 1 (with no request).
  - A reset mid-access aborts it, and the SRAM strobe is released on that edge.

## Timing
- Request visible in cycle 0 (IDLE): `ready` = 0 in the same cycle.
- LOW occupies cycles 1..W and HIGH occupies W+1..2W. DONE is cycle 2W+1 with `ready` = 1.
- Freeze length is 2W+1 cycles; the instruction advances at the end of cycle 2W+1.
- With W = 2: `ready` is low for 5 cycles and high on the 6th.
- Read data is sampled at the end of the last cycle of each phase, so the SRAM access time must be at most W clock periods.
- A new request can be accepted in the first IDLE cycle after DONE, so back-to-back accesses are spaced 2W+2 cycles apart.

## Test plan
- **Reset:** hold `rst` = 0 for 2 cycles with rd_en = 1 → `ready` = 1 after release with no request, `sram_we_n` = 1, `sram_dq_oe` = 0, `read_data` = 0.
- **Write (W = 2):** wr_en, address 1032, data 0xDEADBEEF →
  - `sram_addr` = 4 in cycles 1-2 and 5 in cycles 3-4.
  - `sram_dq_out` = 0xBEEF then 0xDEAD.
  - `sram_we_n` = 0 only in cycles 1 and 3.
  - `ready` = 0 in cycles 0-4 and 1 in cycle 5.
- **Read-back:** SRAM model preloaded by the previous write; rd_en, address 1032 → `read_data` = 0xDEADBEEF in DONE with `ready` = 1; `sram_we_n` stays 1 throughout.
- **Held request:** rd_en held high through DONE and the following cycle → exactly one access per DONE, and a second access starts in the cycle after DONE.
- **Abort:** `rst` = 0 during HIGH of a write → next cycle state IDLE, `sram_we_n` = 1, `sram_dq_oe` = 0, `ready` = 1 (with no request).
- **Simultaneous requests:** rd_en = wr_en = 1, address 1024, data 0x12345678 → SRAM words 0/1 = 0x5678/0x1234; `read_data` is unchanged.
